// File: rtl/axi4_dma_pkg.sv
// Shared AXI4 definitions for the DMA/memory slice.
// Contents: burst type codes, response codes, read-side FSM state enum.
package axi4_dma_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axi4_rd_fifo.sv
// Two-entry output buffer for R beats.
// Ports: clk_i/rst_ni (async active-low), push_i/data_i write side,
//        pop_i/data_o read side (data_o is the head entry),
//        full_o/empty_o status. Push while full is accepted only together
//        with a pop, so simultaneous push/pop keeps occupancy unchanged.
module axi4_rd_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wptr_q;
  logic             rptr_q;
  logic [1:0]       cnt_q;
  logic             push_ok;
  logic             pop_ok;

  always_comb begin
    full_o  = (cnt_q == 2'd2);
    empty_o = (cnt_q == 2'd0);
    pop_ok  = pop_i && !empty_o;
    push_ok = push_i && (!full_o || pop_i);
    data_o  = mem_q[rptr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= ~wptr_q;
      end
      if (pop_ok) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_q + 2'(push_ok) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/axi4_mem_rd.sv
// AXI4 read slave in front of a simple-dual-port memory read port
// (read latency 1, enable tied high).
// Ports: clk, rst_n (async active-low); AR channel arid/araddr/arlen/
//        arsize/arburst/arvalid/arready; R channel rid/rdata/rresp/rlast/
//        rvalid/rready; memory read port addrb (word address) / doutb.
// FIXED holds the word address, INCR advances it modulo DEPTH; WRAP,
// reserved bursts and unsupported sizes return SLVERR beats with zero data.
module axi4_mem_rd
  import axi4_dma_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned ID_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ID_W-1:0]          arid,
  input  logic [ADDR_W-1:0]        araddr,
  input  logic [7:0]               arlen,
  input  logic [2:0]               arsize,
  input  logic [1:0]               arburst,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [ID_W-1:0]          rid,
  output logic [DATA_SIZE-1:0]     rdata,
  output logic [1:0]               rresp,
  output logic                     rlast,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [$clog2(DEPTH)-1:0] addrb,
  input  logic [DATA_SIZE-1:0]     doutb
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned BSH = $clog2(DATA_SIZE / 8);
  localparam int unsigned FW  = ID_W + DATA_SIZE + 3;

  rd_state_e       state_q;
  logic            arready_q;
  logic [ID_W-1:0] id_q;
  logic [AW-1:0]   addr_q;
  logic [7:0]      cnt_q;
  logic            incr_q;
  logic            err_q;

  // One read is in flight between issue and FIFO push.
  logic            inf_q;
  logic [ID_W-1:0] inf_id_q;
  logic            inf_err_q;
  logic            inf_last_q;

  logic [AW-1:0]        word_addr;
  logic                 err_d;
  logic                 pop;
  logic                 issue;
  logic [1:0]           occ;
  logic [1:0]           occ_left;
  logic [1:0]           credit;
  logic [DATA_SIZE-1:0] beat_data;
  logic [FW-1:0]        fifo_din;
  logic [FW-1:0]        fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;

  always_comb begin
    word_addr = AW'(araddr >> BSH);
    err_d     = (arburst == BURST_WRAP) || (arburst == 2'b11) ||
                (arsize != 3'(BSH));
    pop       = !fifo_empty && rready;
    occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    // Counting this cycle's pop keeps one beat per clock with only two
    // buffer slots while still never pushing into a full FIFO.
    occ_left  = occ - {1'b0, pop};
    credit    = occ_left + {1'b0, inf_q};
    issue     = (state_q == ST_BURST) && (credit < 2'd2);
    beat_data = inf_err_q ? '0 : doutb;
    fifo_din  = {inf_id_q, beat_data,
                 (inf_err_q ? RESP_SLVERR : RESP_OKAY), inf_last_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      incr_q     <= 1'b0;
      err_q      <= 1'b0;
      inf_q      <= 1'b0;
      inf_id_q   <= '0;
      inf_err_q  <= 1'b0;
      inf_last_q <= 1'b0;
    end else begin
      inf_q      <= issue;
      inf_id_q   <= id_q;
      inf_err_q  <= err_q;
      inf_last_q <= (cnt_q == 8'd0);
      case (state_q)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (arvalid && arready_q) begin
            id_q      <= arid;
            addr_q    <= word_addr;
            cnt_q     <= arlen;
            incr_q    <= (arburst == BURST_INCR);
            err_q     <= err_d;
            state_q   <= ST_BURST;
            arready_q <= 1'b0;
          end
        end
        ST_BURST: begin
          if (issue) begin
            if (incr_q) begin
              addr_q <= addr_q + AW'(1);
            end
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd0) begin
              state_q   <= ST_IDLE;
              arready_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axi4_rd_fifo #(
    .WIDTH(FW)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (inf_q),
    .data_i (fifo_din),
    .pop_i  (pop),
    .data_o (fifo_dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign {rid, rdata, rresp, rlast} = fifo_dout;
  assign rvalid  = !fifo_empty;
  assign arready = arready_q;
  assign addrb   = addr_q;

endmodule

// File: doc/axi4_mem_rd.md
AXI4_MEM_RD -- requirements
Module: axi4_mem_rd

Interface
REQ-001 SHALL have parameter DEPTH, default 8, memory depth in words (power of two, >=2).
REQ-002 SHALL have parameter DATA_SIZE, default 32, data width in bits (multiple of 8).
REQ-003 SHALL have parameter ADDR_W, default 32, AXI byte-address width.
REQ-004 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-005 SHALL have ports in this order:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arid  in  ID_W  AR transaction ID.
- araddr  in  ADDR_W  AR byte address.
- arlen  in  8  beats minus one.
- arsize  in  3  beat size code.
- arburst  in  2  burst type.
- arvalid  in  1  AR valid.
- arready  out  1  AR ready.
- rid  out  ID_W  R beat ID.
- rdata  out  DATA_SIZE  R beat data.
- rresp  out  2  R beat response.
- rlast  out  1  last beat of burst.
- rvalid  out  1  R valid.
- rready  in  1  R ready.
- addrb  out  $clog2(DEPTH)  read address to the memory block.
- doutb  in  DATA_SIZE  read data from the memory block.

Function
REQ-006 SHALL drive the simple-dual-port memory read port (enable tied high) and assume fixed read latency of 1: doutb is valid the cycle after addrb is presented.
REQ-007 SHALL implement FSM IDLE/BURST; arready=1 only in IDLE; AR handshake (arvalid&arready) captures arid/araddr/arlen/arsize/arburst and moves to BURST next cycle.
REQ-008 SHALL form word address = araddr >> $clog2(DATA_SIZE/8), truncated to $clog2(DEPTH) bits; increments wrap modulo DEPTH.
REQ-009 SHALL advance the word address by 1 per issued beat for INCR (2'b01) and hold it for FIXED (2'b00).
REQ-010 SHALL answer WRAP (2'b10), reserved (2'b11), or arsize != $clog2(DATA_SIZE/8) with arlen+1 beats of rresp=SLVERR (2'b10), rdata=0; otherwise rresp=OKAY (2'b00).
REQ-011 SHALL issue a read (present addrb) only when FIFO occupancy plus reads in flight < 2, guaranteeing no beat is lost under rready backpressure.
REQ-012 SHALL write each returned beat {rid, doutb or 0, rresp, rlast} into a 2-entry output FIFO one cycle after issue; FIFO head drives R outputs, rvalid = FIFO not empty.
REQ-013 SHALL sustain one beat per clock when rready is held high; first rvalid appears 3 cycles after AR handshake.
REQ-014 SHALL assert rlast on exactly beat arlen (zero-based); arlen=0 yields one beat with rlast=1.
REQ-015 SHALL return to IDLE the cycle after the last read is issued, accepting a new AR while prior beats still drain; beat order across bursts preserved.
REQ-016 SHALL keep rid/rdata/rresp/rlast stable while rvalid=1 and rready=0.
REQ-017 SHALL handle simultaneous FIFO push and pop with occupancy unchanged.

Reset
REQ-018 SHALL, on rst_n low, asynchronously clear: FSM to IDLE, FIFO empty, in-flight flag 0, addrb=0, rvalid=0, rlast=0, rresp=0, rid=0, rdata=0, arready=0.
REQ-019 SHALL drive arready=1 from the first clock edge after rst_n deasserts.
REQ-020 SHALL discard any burst in progress and buffered beats on reset assertion mid-burst; no R beat emitted after deassertion until a new AR.

Structure
REQ-021 SHALL take burst-type codes (FIXED/INCR/WRAP), response codes (OKAY/SLVERR) and the FSM state enum from shared package axi4_dma_pkg.
REQ-022 SHALL place the 2-entry output buffer in sub-module axi4_rd_fifo (parameterised width, async active-low reset, push/pop/full/empty).

Verification
REQ-023 Memory preloaded word[k]=0x100+k, DEPTH=8: AR addr 0x0, len 3, INCR, size 2, rready=1 -> beats 0x100..0x103, OKAY, rlast on beat 3, back-to-back cycles.
REQ-024 AR addr 0x18 (word 6), len 3, INCR -> data 0x106,0x107,0x100,0x101 (address wraps at DEPTH).
REQ-025 AR len 7, rready toggled 1/0 each cycle -> all 8 beats 0x100..0x107 in order, no drop/duplicate, R fields stable while stalled.
REQ-026 AR arburst=WRAP, len 1, id 5 -> two beats rid=5, rresp=SLVERR, rdata=0, rlast on second.
REQ-027 AR addr 0x8, len 0, FIXED, id 3, immediately followed by AR addr 0x0, len 1, id 9 -> beats (3,0x102,last) then (9,0x100),(9,0x101,last).
REQ-028 rst_n pulsed low mid-burst of len 7 with rready=0 -> rvalid=0 immediately, arready=1 one clock after release, no stale beats.
